// File: rtl/run_detector.sv
// Serial run detector: counts consecutive equal bits, flags runs of RUN_LEN,
// and keeps a saturating tally of completed matches.
module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  input  logic             w,
  input  logic             clr,
  input  logic             rearm,
  output logic             z,
  output logic             z_val,
  output logic             hit,
  output logic [3:0]       run,
  output logic [CNT_W-1:0] det_count
);

  typedef enum logic [1:0] {IDLE, ZEROS, ONES} state_e;

  localparam logic [3:0]       RUN_MAX = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             hit_q, hit_d;
  logic             z_q, z_val_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      run_d   = 4'd0;
      cnt_d   = '0;
    end else if (en) begin
      if (state_q == IDLE || w != (state_q == ONES)) begin
        state_d = w ? ONES : ZEROS;
        run_d   = 4'd1;
      end else if (run_q == RUN_MAX) begin
        // A full run either holds (no new hit) or starts a fresh, non-overlapping one.
        run_d = rearm ? 4'd1 : RUN_MAX;
      end else begin
        run_d = run_q + 4'd1;
        hit_d = (run_d == RUN_MAX);
      end
      if (hit_d && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      run_q   <= 4'd0;
      hit_q   <= 1'b0;
      z_q     <= 1'b0;
      z_val_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hit_q   <= hit_d;
      z_q     <= (run_d == RUN_MAX);
      z_val_q <= (state_d == ONES);
      cnt_q   <= cnt_d;
    end
  end

  assign z         = z_q;
  assign z_val     = z_val_q;
  assign hit       = hit_q;
  assign run       = run_q;
  assign det_count = cnt_q;

endmodule

// File: tb/tb_run_detector.sv
// Directed table-driven bench for run_detector plus hand sequences for
// asynchronous reset and counter saturation on a narrow-counter instance.
module tb_run_detector;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       en = 1'b0, w = 1'b0, clr = 1'b0, rearm = 1'b0;
  logic       z, z_val, hit;
  logic [3:0] run;
  logic [7:0] det_count;
  logic       z2, z_val2, hit2;
  logic [3:0] run2;
  logic [1:0] det_count2;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  run_detector #(.RUN_LEN(4), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .en(en), .w(w), .clr(clr), .rearm(rearm),
    .z(z), .z_val(z_val), .hit(hit), .run(run), .det_count(det_count)
  );

  run_detector #(.RUN_LEN(4), .CNT_W(2)) dut_narrow (
    .Clock(Clock), .Reset(Reset), .en(en), .w(w), .clr(clr), .rearm(rearm),
    .z(z2), .z_val(z_val2), .hit(hit2), .run(run2), .det_count(det_count2)
  );

  typedef struct {
    logic       clr, en, w, rearm;
    logic [3:0] run;
    logic       z, zv, hit;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic e, logic wi, logic r,
                              logic [3:0] rn, logic zz, logic zv, logic h, logic [7:0] cn);
    vec_t v;
    v.clr = c; v.en = e; v.w = wi; v.rearm = r;
    v.run = rn; v.z = zz; v.zv = zv; v.hit = h; v.cnt = cn;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(string tag, int idx, logic [3:0] erun, logic ez, logic ezv,
                           logic eh, logic [7:0] ecnt);
    check({tag, ".run"}, idx, 32'(run), 32'(erun));
    check({tag, ".z"}, idx, 32'(z), 32'(ez));
    check({tag, ".z_val"}, idx, 32'(z_val), 32'(ezv));
    check({tag, ".hit"}, idx, 32'(hit), 32'(eh));
    check({tag, ".det_count"}, idx, 32'(det_count), 32'(ecnt));
  endtask

  task automatic step(logic c, logic e, logic wi, logic r);
    clr = c; en = e; w = wi; rearm = r;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // run-of-zeros, hold mode: saturate at 4, single hit
    vecs.push_back(mk(0,1,0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0, 2,0,0,0,0));
    vecs.push_back(mk(0,1,0,0, 3,0,0,0,0));
    vecs.push_back(mk(0,1,0,0, 4,1,0,1,1));
    vecs.push_back(mk(0,1,0,0, 4,1,0,0,1));
    vecs.push_back(mk(1,1,1,0, 0,0,0,0,0));
    // polarity switch mid-run
    vecs.push_back(mk(0,1,0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0, 2,0,0,0,0));
    vecs.push_back(mk(0,1,0,0, 3,0,0,0,0));
    vecs.push_back(mk(0,1,1,0, 1,0,1,0,0));
    vecs.push_back(mk(0,1,1,0, 2,0,1,0,0));
    vecs.push_back(mk(0,1,1,0, 3,0,1,0,0));
    vecs.push_back(mk(0,1,1,0, 4,1,1,1,1));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0));
    // restart mode: eight ones, two hits
    vecs.push_back(mk(0,1,1,1, 1,0,1,0,0));
    vecs.push_back(mk(0,1,1,1, 2,0,1,0,0));
    vecs.push_back(mk(0,1,1,1, 3,0,1,0,0));
    vecs.push_back(mk(0,1,1,1, 4,1,1,1,1));
    vecs.push_back(mk(0,1,1,1, 1,0,1,0,1));
    vecs.push_back(mk(0,1,1,1, 2,0,1,0,1));
    vecs.push_back(mk(0,1,1,1, 3,0,1,0,1));
    vecs.push_back(mk(0,1,1,1, 4,1,1,1,2));
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,0));
    // enable gating, then rearm change while idle-enabled
    vecs.push_back(mk(0,1,1,0, 1,0,1,0,0));
    vecs.push_back(mk(0,1,1,0, 2,0,1,0,0));
    vecs.push_back(mk(0,1,1,0, 3,0,1,0,0));
    vecs.push_back(mk(0,0,0,0, 3,0,1,0,0));
    vecs.push_back(mk(0,0,1,0, 3,0,1,0,0));
    vecs.push_back(mk(0,0,0,0, 3,0,1,0,0));
    vecs.push_back(mk(0,1,1,0, 4,1,1,1,1));
    vecs.push_back(mk(0,0,1,0, 4,1,1,0,1));
    vecs.push_back(mk(0,0,1,1, 4,1,1,0,1));
    vecs.push_back(mk(0,1,1,1, 1,0,1,0,1));
    vecs.push_back(mk(0,1,0,1, 1,0,0,0,1));

    // reset state
    repeat (2) @(posedge Clock);
    #1;
    check_all("reset", 0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].w, vecs[i].rearm);
      check_all("vec", i, vecs[i].run, vecs[i].z, vecs[i].zv, vecs[i].hit, vecs[i].cnt);
    end

    // asynchronous reset mid-run, between edges
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    check("pre_reset.run", 0, 32'(run), 32'd3);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_all("async_rst", 0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(0, 1, 1, 0);
    check_all("rst_held", 0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge Clock);
    Reset = 1'b0;
    step(0, 1, 1, 0);
    check_all("post_rst", 0, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0);

    // narrow counter saturation under restart mode
    step(1, 1, 0, 1);
    check("narrow.clr", 0, 32'(det_count2), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, 1);
      if (i % 4 == 0)
        check("narrow.det_count", i, 32'(det_count2), (i / 4 > 3) ? 32'd3 : 32'(i / 4));
    end
    check("narrow.run", 20, 32'(run2), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
